// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with jump redirect, stall hold and optional halt (SWT16_FETCH_HALT_EN)
module fetch_unit #(
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_stall,
  input  logic                       in_jump_valid,
  input  logic [PC_WIDTH-1:0]        in_jump_target,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_rdata,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic                       out_pmem_ren,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_instr_valid,
  output logic                       out_halted
);
`ifdef SWT16_FETCH_HALT_EN
  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
`endif
  state_t state, state_nx;
  logic [PC_WIDTH-1:0] pc_fetch, pc_fetch_nx, pc_issue, pc_issue_nx;
  logic run;
  // state and both program counters; reset abandons any in-flight fetch
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= BOOT;
      pc_fetch <= '0;
      pc_issue <= '0;
    end else begin
      state    <= state_nx;
      pc_fetch <= pc_fetch_nx;
      pc_issue <= pc_issue_nx;
    end
  // advance the fetch pointer; a jump overrides everything, including stall and halt
  always_comb begin
    state_nx    = state;
    pc_fetch_nx = pc_fetch;
    pc_issue_nx = pc_issue;
    case (state)
      BOOT, FLUSH: begin
        state_nx    = RUN;
        pc_fetch_nx = pc_fetch + 1'b1;
        pc_issue_nx = pc_fetch;
      end
      RUN: if (!in_stall) begin
        pc_fetch_nx = pc_fetch + 1'b1;
        pc_issue_nx = pc_fetch;
`ifdef SWT16_FETCH_HALT_EN
        if (in_pmem_rdata == '1) state_nx = HALT;
`endif
      end
      default: ;
    endcase
    if (in_jump_valid) begin
      state_nx    = FLUSH;
      pc_fetch_nx = in_jump_target;
      pc_issue_nx = pc_issue;
    end
  end
  assign run             = !reset && state == RUN;
  assign out_pmem_addr   = PMEM_ADDR_WIDTH'(pc_fetch);
  assign out_pmem_ren    = !reset && (state == BOOT || state == FLUSH || (state == RUN && (!in_stall || in_jump_valid)));
  assign out_instr_valid = run;
  assign out_instr       = run ? in_pmem_rdata : '0;
  assign out_pc          = pc_issue;
`ifdef SWT16_FETCH_HALT_EN
  assign out_halted      = !reset && state == HALT;
`else
  assign out_halted      = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand sequences and randomized model check for fetch_unit
module tb_fetch_unit;
  logic        clock = 1'b0, reset = 1'b1, in_stall = 1'b0, in_jump_valid = 1'b0;
  logic [11:0] in_jump_target = '0;
  logic [15:0] in_pmem_rdata = '0;
  logic [11:0] out_pmem_addr, out_pc;
  logic [15:0] out_instr;
  logic        out_pmem_ren, out_instr_valid, out_halted;
  logic [15:0] mem [4096];
  int checks = 0, errors = 0;
  logic [11:0] m_cur;
  int          m_bub;
  logic        m_halt;

  typedef struct {
    logic stall, jv; logic [11:0] tgt;
    logic valid; logic [11:0] pc; logic [15:0] instr; logic ren; logic [11:0] addr;
  } vec_t;
  vec_t tv[21];

  fetch_unit dut (
    .clock(clock), .reset(reset), .in_stall(in_stall), .in_jump_valid(in_jump_valid),
    .in_jump_target(in_jump_target), .in_pmem_rdata(in_pmem_rdata),
    .out_pmem_addr(out_pmem_addr), .out_pmem_ren(out_pmem_ren), .out_instr(out_instr),
    .out_pc(out_pc), .out_instr_valid(out_instr_valid), .out_halted(out_halted)
  );

  always #5 clock = ~clock;
  // one-cycle program memory that holds its data while not read
  always @(posedge clock) if (out_pmem_ren) in_pmem_rdata <= mem[out_pmem_addr];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int st, int jv, int tg, int v, int pc, int ins, int rn, int ad);
    mk.stall = st[0]; mk.jv = jv[0]; mk.tgt = tg[11:0];
    mk.valid = v[0]; mk.pc = pc[11:0]; mk.instr = ins[15:0]; mk.ren = rn[0]; mk.addr = ad[11:0];
  endfunction

  task automatic drive(logic st, logic jv, logic [11:0] tg);
    in_stall = st; in_jump_valid = jv; in_jump_target = tg; #1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ren"}, out_pmem_ren, 0);
    chk({tag, "_addr"}, out_pmem_addr, 0);
    chk({tag, "_valid"}, out_instr_valid, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_halted"}, out_halted, 0);
  endtask

  // one cycle of random stimulus against the issued-address stream model
  task automatic rstep(logic st, logic jv, logic [11:0] tg);
    logic ev;
    drive(st, jv, tg);
    ev = !m_halt && m_bub == 0;
    chk("r_valid", out_instr_valid, ev);
    chk("r_instr", out_instr, ev ? mem[m_cur] : 16'h0);
    if (ev) chk("r_pc", out_pc, m_cur);
    chk("r_ren", out_pmem_ren, m_halt ? 1'b0 : (m_bub > 0 || !st || jv));
    chk("r_addr", out_pmem_addr, m_bub > 0 ? m_cur : 12'(m_cur + 1));
    chk("r_halted", out_halted, m_halt);
    @(posedge clock);
    if (jv) begin
      m_cur = tg; m_bub = 1; m_halt = 1'b0;
    end else if (m_halt) begin
    end else if (m_bub > 0) begin
      m_bub--;
    end else if (!st) begin
`ifdef SWT16_FETCH_HALT_EN
      if (mem[m_cur] == 16'hFFFF) m_halt = 1'b1;
`endif
      m_cur = m_cur + 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    for (int n = 0; n < 4096; n++) mem[n] = 16'(n + 'h100);
    mem[12'h080] = 16'hFFFF;
    tv[0]  = mk(1, 0, 0,     0, 0,     0,      1, 0);
    tv[1]  = mk(0, 0, 0,     1, 0,     'h100,  1, 1);
    tv[2]  = mk(0, 0, 0,     1, 1,     'h101,  1, 2);
    tv[3]  = mk(0, 0, 0,     1, 2,     'h102,  1, 3);
    tv[4]  = mk(1, 1, 'h010, 1, 3,     'h103,  1, 4);
    tv[5]  = mk(1, 0, 0,     0, 0,     0,      1, 'h010);
    tv[6]  = mk(0, 1, 5,     1, 'h010, 'h110,  1, 'h011);
    tv[7]  = mk(0, 0, 0,     0, 0,     0,      1, 5);
    tv[8]  = mk(1, 0, 0,     1, 5,     'h105,  0, 6);
    tv[9]  = mk(1, 0, 0,     1, 5,     'h105,  0, 6);
    tv[10] = mk(1, 0, 0,     1, 5,     'h105,  0, 6);
    tv[11] = mk(0, 0, 0,     1, 5,     'h105,  1, 6);
    tv[12] = mk(0, 0, 0,     1, 6,     'h106,  1, 7);
    tv[13] = mk(0, 1, 'h040, 1, 7,     'h107,  1, 8);
    tv[14] = mk(0, 0, 0,     0, 0,     0,      1, 'h040);
    tv[15] = mk(0, 1, 'hFFE, 1, 'h040, 'h140,  1, 'h041);
    tv[16] = mk(0, 0, 0,     0, 0,     0,      1, 'hFFE);
    tv[17] = mk(0, 0, 0,     1, 'hFFE, 'h10FE, 1, 'hFFF);
    tv[18] = mk(0, 0, 0,     1, 'hFFF, 'h10FF, 1, 0);
    tv[19] = mk(0, 0, 0,     1, 0,     'h100,  1, 1);
    tv[20] = mk(0, 0, 0,     1, 1,     'h101,  1, 2);

    repeat (2) @(negedge clock);
    chk_reset("rst");
    reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].stall, tv[i].jv, tv[i].tgt);
      chk($sformatf("tv%0d_valid", i), out_instr_valid, tv[i].valid);
      chk($sformatf("tv%0d_instr", i), out_instr, tv[i].instr);
      if (tv[i].valid) chk($sformatf("tv%0d_pc", i), out_pc, tv[i].pc);
      chk($sformatf("tv%0d_ren", i), out_pmem_ren, tv[i].ren);
      chk($sformatf("tv%0d_addr", i), out_pmem_addr, tv[i].addr);
      chk($sformatf("tv%0d_halted", i), out_halted, 0);
      @(negedge clock);
    end

    drive(1, 0, 0);
    #1 reset = 1'b1; #1;
    chk_reset("midrst");
    @(negedge clock);
    mem[4] = 16'hFFFF;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0); @(negedge clock); end
    drive(0, 0, 0);
    chk("hw_pc", out_pc, 4);
    chk("hw_instr", out_instr, 16'hFFFF);
    chk("hw_valid", out_instr_valid, 1);
    @(negedge clock);
    drive(0, 0, 0);
`ifdef SWT16_FETCH_HALT_EN
    chk("h_halted", out_halted, 1);
    chk("h_valid", out_instr_valid, 0);
    chk("h_instr", out_instr, 0);
    chk("h_ren", out_pmem_ren, 0);
    @(negedge clock);
    drive(1, 0, 0);
    chk("h_hold", out_halted, 1);
    @(negedge clock);
    drive(0, 1, 0);
    chk("h_jmp_halted", out_halted, 1);
    @(negedge clock);
    drive(0, 0, 0);
    chk("h_flush_halted", out_halted, 0);
    chk("h_flush_valid", out_instr_valid, 0);
    chk("h_flush_addr", out_pmem_addr, 0);
    @(negedge clock);
    drive(0, 0, 0);
    chk("h_resume_pc", out_pc, 0);
    chk("h_resume_valid", out_instr_valid, 1);
`else
    chk("nh_pc", out_pc, 5);
    chk("nh_valid", out_instr_valid, 1);
    chk("nh_instr", out_instr, 16'h0105);
    chk("nh_halted", out_halted, 0);
`endif
    mem[4] = 16'h0104;
    @(negedge clock);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_cur = '0; m_bub = 1; m_halt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1; #1;
        chk_reset("r_rst");
        @(negedge clock);
        reset = 1'b0;
        m_cur = '0; m_bub = 1; m_halt = 1'b0;
      end
      rstep($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0 ? 12'($urandom_range('hFF0, 'hFFF)) : 12'($urandom_range(0, 255)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
